// File: rtl/cosine_pkg.sv
// Shared types and constants for the cosine distance engine.
package cosine_pkg;

  localparam int unsigned W         = 16;
  localparam int unsigned FRAC_BITS = 11;
  localparam int unsigned N_TERMS   = 5;
  localparam int unsigned K_W       = 4;

  localparam logic [W-1:0] ONE = 16'h0800;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LOAD  = 4'd1,
    S_SQR   = 4'd2,
    S_MULX  = 4'd3,
    S_MULR  = 4'd4,
    S_ACC   = 4'd5,
    S_FINAL = 4'd6,
    S_DONE  = 4'd7
  } state_t;

  // 1/((2k-1)(2k)) in Q5.11, rounded to nearest
  function automatic logic [W-1:0] recip(input logic [K_W-1:0] k);
    case (k)
      4'd1:    recip = 16'h0400;
      4'd2:    recip = 16'h00AB;
      4'd3:    recip = 16'h0044;
      4'd4:    recip = 16'h0025;
      4'd5:    recip = 16'h0017;
      default: recip = '0;
    endcase
  endfunction

endpackage

// File: rtl/cosine_ctrl.sv
// Control FSM sequencing load, squaring, the Taylor term loop and the final scale.
module cosine_ctrl
  import cosine_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   i_start,
  input  logic   i_stop,
  output state_t o_state
);

  state_t r_state;
  state_t w_next;

  // State register with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; start is only honoured in IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_LOAD;
      S_LOAD:  w_next = S_SQR;
      S_SQR:   w_next = S_MULX;
      S_MULX:  w_next = S_MULR;
      S_MULR:  w_next = S_ACC;
      S_ACC:   w_next = i_stop ? S_FINAL : S_MULX;
      S_FINAL: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign o_state = r_state;

endmodule

// File: rtl/cosine_dp.sv
// Datapath: operand registers, one shared Q5.11 multiplier, accumulator and term counter.
module cosine_dp
  import cosine_pkg::*;
#(
  parameter int unsigned N_TERMS = cosine_pkg::N_TERMS
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  state_t       i_state,
  input  logic [W-1:0] i_v,
  input  logic [W-1:0] i_x,
  output logic         o_stop,
  output logic [W-1:0] o_distance,
  output logic         o_done
);

  logic [W-1:0]   r_v, r_x, r_x2, r_term, r_sum, r_distance;
  logic [K_W-1:0] r_k;
  logic           r_done;

  logic [W-1:0]          w_a, w_b, w_res;
  logic signed [26:0]    w_prod;
  logic [FRAC_BITS-1:0]  w_unused_frac;

  // Multiplier operand select by state
  always_comb begin
    w_a = '0;
    w_b = '0;
    case (i_state)
      S_SQR:   begin w_a = r_x;    w_b = r_x;        end
      S_MULX:  begin w_a = r_term; w_b = r_x2;       end
      S_MULR:  begin w_a = r_term; w_b = recip(r_k); end
      S_FINAL: begin w_a = r_v;    w_b = r_sum;      end
      default: ;
    endcase
  end

  // Only product bits [26:11] are kept, so the product is formed at 27 bits
  assign w_prod = $signed(w_a) * $signed(w_b);
  assign {w_res, w_unused_frac} = w_prod;

  assign o_stop = (r_k == K_W'(N_TERMS));

  // Register updates driven by the current control state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v        <= '0;
      r_x        <= '0;
      r_x2       <= '0;
      r_term     <= '0;
      r_sum      <= '0;
      r_distance <= '0;
      r_k        <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (i_state == S_FINAL);
      case (i_state)
        S_LOAD: begin
          r_v    <= i_v;
          r_x    <= i_x;
          r_sum  <= ONE;
          r_term <= ONE;
          r_k    <= 4'd1;
        end
        S_SQR:   r_x2 <= w_res;
        S_MULX:  r_term <= w_res;
        S_MULR:  r_term <= -w_res;
        S_ACC: begin
          r_sum <= r_sum + r_term;
          r_k   <= r_k + 4'd1;
        end
        S_FINAL: r_distance <= w_res;
        default: ;
      endcase
    end
  end

  assign o_distance = r_distance;
  assign o_done     = r_done;

endmodule

// File: rtl/cosine_distance.sv
// Top: distance = vSig * cos(XSig); wires the control FSM to the datapath.
module cosine_distance
  import cosine_pkg::*;
#(
  parameter int unsigned N_TERMS = cosine_pkg::N_TERMS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] vSig,
  input  logic [15:0] XSig,
  output logic [15:0] distance,
  output logic        done,
  output logic [3:0]  state
);

  state_t w_state;
  logic   w_stop;

  cosine_ctrl u_ctrl (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_stop  (w_stop),
    .o_state (w_state)
  );

  cosine_dp #(.N_TERMS(N_TERMS)) u_dp (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_state    (w_state),
    .i_v        (vSig),
    .i_x        (XSig),
    .o_stop     (w_stop),
    .o_distance (distance),
    .o_done     (done)
  );

  assign state = w_state;

endmodule

// File: tb/tb_cosine_distance.sv
// Self-checking bench for cosine_distance with a result scoreboard.
module tb_cosine_distance;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] vSig, XSig;
  logic [15:0] distance;
  logic        done;
  logic [3:0]  state;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [15:0] exp_q[$];

  cosine_distance #(.N_TERMS(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .vSig     (vSig),
    .XSig     (XSig),
    .distance (distance),
    .done     (done),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: Q5.11 multiply keeps product bits [26:11]
  function automatic logic signed [15:0] qmul(input logic signed [15:0] a, input logic signed [15:0] b);
    logic signed [31:0] p;
    p = 32'(a) * 32'(b);
    return p[26:11];
  endfunction

  function automatic logic [15:0] model(input logic [15:0] v, input logic [15:0] x);
    logic signed [15:0] rc [1:5];
    logic signed [15:0] x2, term, sum;
    rc[1] = 16'sh0400; rc[2] = 16'sh00AB; rc[3] = 16'sh0044;
    rc[4] = 16'sh0025; rc[5] = 16'sh0017;
    x2   = qmul(x, x);
    term = 16'sh0800;
    sum  = 16'sh0800;
    for (int k = 1; k <= 5; k++) begin
      term = qmul(term, x2);
      term = -qmul(term, rc[k]);
      sum  = sum + term;
    end
    return qmul(v, sum);
  endfunction

  // Drive one start pulse (or leave start high) and push the expected result
  task automatic launch(input logic [15:0] v, input logic [15:0] x, input bit hold);
    @(negedge clk);
    vSig  = v;
    XSig  = x;
    start = 1'b1;
    exp_q.push_back(model(v, x));
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  // Wait for done; cyc counts edges since the start edge, inclusive
  task automatic finish_run(input string tag, input int cyc0, input logic [15:0] approx);
    int cyc;
    int diff;
    logic [15:0] exp;
    cyc = cyc0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    exp = exp_q.pop_front();
    if (!done) begin
      check_eq({tag, "_timeout"}, 32'(done), 32'd1);
    end else begin
      check_eq({tag, "_latency"}, 32'(cyc), 32'd19);
      check_eq({tag, "_dist"}, 32'(distance), 32'(exp));
      diff = int'($signed(distance)) - int'($signed(approx));
      check_eq({tag, "_within6"}, 32'(diff <= 6 && diff >= -6), 32'd1);
      check_eq({tag, "_state"}, 32'(state), 32'd7);
      @(negedge clk);
      check_eq({tag, "_pulse_end"}, 32'(done), 32'd0);
    end
  endtask

  task automatic count_extra_done(input string tag, input int ncyc);
    int pulses;
    pulses = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check_eq(tag, 32'(pulses), 32'd0);
  endtask

  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0; vSig = '0; XSig = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_dist", 32'(distance), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_state", 32'(state), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("idle_hold", {15'd0, done, distance}, 32'd0);
      check_eq("idle_state", 32'(state), 32'd0);
    end

    // Basic run: 1.0 * cos(0.5)
    launch(16'h0800, 16'h0400, 1'b0);
    finish_run("basic", 1, 16'h0705);
    count_extra_done("basic_single", 5);
    check_eq("dist_hold", 32'(distance), 32'h0706);

    // Negative magnitude, larger angle
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    launch(16'hF400, 16'h0946, 1'b0);
    finish_run("neg", 1, 16'hFB32);
    count_extra_done("neg_single", 5);

    // Zero angle is exact
    launch(16'h1000, 16'h0000, 1'b0);
    finish_run("zero", 1, 16'h1000);

    // Reset mid-run: rst arrives 8 cycles after the start edge
    launch(16'h0800, 16'h0400, 1'b0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 7; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_state", 32'(state), 32'd0);
    check_eq("abort_dist", 32'(distance), 32'd0);
    count_extra_done("abort_no_done", 25);
    launch(16'h1000, 16'h0000, 1'b0);
    finish_run("after_abort", 1, 16'h1000);

    // Start pulsed while busy in MULX is ignored
    launch(16'h0800, 16'h0400, 1'b0);
    cyc = 1;
    while (state != 4'd3 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("busy_reach_mulx", 32'(state), 32'd3);
    start = 1'b1;
    @(negedge clk);
    cyc++;
    start = 1'b0;
    finish_run("busy", cyc, 16'h0705);
    count_extra_done("busy_single", 25);

    // Start held high across DONE relaunches from IDLE
    launch(16'h1000, 16'h0000, 1'b1);
    finish_run("held", 1, 16'h1000);
    check_eq("held_idle", 32'(state), 32'd0);
    @(negedge clk);
    check_eq("held_relaunch", 32'(state), 32'd1);
    start = 1'b0;
    exp_q.push_back(model(16'h1000, 16'h0000));
    finish_run("held2", 1, 16'h1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
